// File: rtl/reg_bus_responder_if.sv
// Register bus request/response channel bundle between initiator and responder.
// Latency: none, wires only.
// Backpressure: valid/ready on both request and response channels.
interface reg_bus_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/reg_bus_responder.sv
// Register bus responder: single-beat read/write against an internal register file; rsp_err via REG_BUS_RESP_ERR_EN.
// Latency: accept at edge N, service in the following cycle, response valid from edge N+1 (sampled at N+2).
// Backpressure: one transaction outstanding; req_ready low until the response handshake completes.
module reg_bus_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_bus_responder_if.slave   bus
);
    localparam int              NB     = DATA_W / 8;
    localparam int              IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                accept;

    // Address width can exceed the register count, so compare against DEPTH with one spare bit.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];
    assign accept   = (state_q == IDLE) && bus.req_valid;

    // Handshake outputs decode straight from the state register.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_rdata = rdata_q;

`ifdef REG_BUS_RESP_ERR_EN
    logic err_q;
    assign bus.rsp_err = err_q;

    // Error flag is captured in the service cycle and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == READ || state_q == WRITE) begin
            err_q <= !in_range;
        end
    end
`else
    assign bus.rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one cycle of service, then wait in DONE for the initiator.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.req_write ? WRITE : READ;
            READ:    state_d = DONE;
            WRITE:   state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured only on acceptance; later changes on req_* are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
        end
    end

    // Read data is registered in the service cycle and stays stable while DONE stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state_q == READ) begin
            rdata_q <= in_range ? regs_q[idx] : '0;
        end else if (state_q == WRITE) begin
            rdata_q <= '0;
        end
    end

    // Register file: byte-lane masked writes, out-of-range writes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == WRITE && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_q[b]) begin
                    regs_q[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_bus_responder.sv
// Self-checking bench for reg_bus_responder: table-driven transactions with a response scoreboard.
// Latency: checks accept -> service -> response timing and the minimum period.
// Backpressure: holds rsp_ready low for several cycles and checks stability and request blocking.
module tb_reg_bus_responder;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
`ifdef REG_BUS_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    reg_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_bus_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        bit          oor;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    // Back-to-back period tracking
    bit   prev_ok   = 1'b0;
    int   prev_acc  = 0;
    int   prev_hold = 0;

    // Request presented while the current one is still in flight
    bit          nxt_wr;
    logic [7:0]  nxt_addr;
    logic [31:0] nxt_wdata;
    logic [3:0]  nxt_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int hold, input bit oor,
                                input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
        v.hold = hold; v.oor = oor; v.exp_rdata = exp;
        return v;
    endfunction

    // Scoreboard: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_rsp: got response rdata %h with no request pending", bus.rsp_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_rdata", bus.rsp_rdata, e.rdata);
                chk("sb_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the response handshake.
    task automatic run_txn(input bit wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold, input logic [31:0] exp_rd,
                           input logic exp_e, input bit keep, output int waited);
        logic [31:0] rd0;
        bit          got;
        exp_t        e;
        int          acc;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        got    = 1'b0;
        waited = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for 20 cycles, required 1");
            bus.req_valid = 1'b0;
            prev_ok = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        if (prev_ok && prev_hold == 0) chk("min_period", acc - prev_acc, 3);
        prev_ok   = 1'b1;
        prev_acc  = acc;
        prev_hold = hold;
        if (keep) begin
            bus.req_write = nxt_wr;
            bus.req_addr  = nxt_addr;
            bus.req_wdata = nxt_wdata;
            bus.req_wstrb = nxt_wstrb;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = 8'($urandom);
            bus.req_wdata = $urandom;
            bus.req_wstrb = 4'($urandom);
        end
        @(negedge clk);
        chk("svc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("svc_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 bus.rsp_ready = (hold == 0);
        @(negedge clk);
        chk("lat_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        rd0 = bus.rsp_rdata;
        chk("lat_rdata", rd0, exp_rd);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (k == hold - 1) bus.rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata_stable", bus.rsp_rdata, rd0);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        vecs[0]  = mk(0, 8'd3,   32'h0000_0000, 4'h0, 0, 0, 32'h0000_0000);
        vecs[1]  = mk(1, 8'd2,   32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0000_0000);
        vecs[2]  = mk(0, 8'd2,   32'h0000_0000, 4'h0, 1, 0, 32'hDEAD_BEEF);
        vecs[3]  = mk(1, 8'd5,   32'h1122_3344, 4'hF, 0, 0, 32'h0000_0000);
        vecs[4]  = mk(1, 8'd5,   32'hAABB_CCDD, 4'h5, 2, 0, 32'h0000_0000);
        vecs[5]  = mk(0, 8'd5,   32'h0000_0000, 4'h0, 0, 0, 32'h11BB_33DD);
        vecs[6]  = mk(1, 8'd5,   32'hFFFF_FFFF, 4'h0, 0, 0, 32'h0000_0000);
        vecs[7]  = mk(0, 8'd5,   32'h0000_0000, 4'h0, 4, 0, 32'h11BB_33DD);
        vecs[8]  = mk(0, 8'd16,  32'h0000_0000, 4'h0, 0, 1, 32'h0000_0000);
        vecs[9]  = mk(1, 8'd200, 32'h1234_5678, 4'hF, 0, 1, 32'h0000_0000);
        vecs[10] = mk(0, 8'd200, 32'h0000_0000, 4'h0, 0, 1, 32'h0000_0000);
        vecs[11] = mk(0, 8'd8,   32'h0000_0000, 4'h0, 0, 0, 32'h0000_0000);
        vecs[12] = mk(0, 8'd15,  32'h0000_0000, 4'h0, 0, 0, 32'h0000_0000);
        vecs[13] = mk(1, 8'd15,  32'hCAFE_F00D, 4'hA, 0, 0, 32'h0000_0000);
        vecs[14] = mk(0, 8'd15,  32'h0000_0000, 4'h0, 3, 0, 32'hCA00_F000);
        vecs[15] = mk(1, 8'd0,   32'h0102_0304, 4'hF, 0, 0, 32'h0000_0000);
        vecs[16] = mk(0, 8'd0,   32'h0000_0000, 4'h0, 0, 0, 32'h0102_0304);
        vecs[17] = mk(0, 8'd2,   32'h0000_0000, 4'h0, 0, 0, 32'hDEAD_BEEF);
        vecs[18] = mk(0, 8'd255, 32'h0000_0000, 4'h0, 0, 1, 32'h0000_0000);

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Main table
        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].hold,
                    vecs[i].exp_rdata, ERR_EN & vecs[i].oor, 1'b0, w);
        end

        // Backpressure with a second request held valid during DONE
        nxt_wr = 1'b0; nxt_addr = 8'd7; nxt_wdata = 32'h0; nxt_wstrb = 4'h0;
        run_txn(1'b1, 8'd7, 32'h0BAD_F00D, 4'hF, 4, 32'h0, 1'b0, 1'b1, w);
        run_txn(1'b0, 8'd7, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, w);
        chk("bp_next_accept_wait", w, 32'd0);

        // Reset asserted while a write response is pending in DONE
        prev_ok       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'd1;
        bus.req_wdata = 32'h5555_AAAA;
        bus.req_wstrb = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rsp_valid_pre", {31'd0, bus.rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid_rst", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_req_ready_rst", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_rdata_rst", bus.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        bus.rsp_ready = 1'b0;
        run_txn(1'b0, 8'd1, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, w);
        run_txn(1'b0, 8'd2, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, w);
        run_txn(1'b0, 8'd5, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
